vga_rx_decoder: RTL
===================

Name: vga_rx_decoder

Overview:
- Receiver and decoder for the VGA output produced by the display pipeline.
- Samples hsync, vsync and RGB on the pixel clock and recovers raster timing from the sync edges.
- Emits valid pixels with x/y coordinates and flags timing errors.
- Used in benches and on hardware loopback to check the frame buffer / fade output against the intended image, pixel by pixel.

Parameters:
- COLOR_BITS, 4, bits per colour channel.
- H_VISIBLE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BACK, 48, horizontal back porch.
- V_VISIBLE, 480, visible lines.
- V_FRONT, 10, vertical front porch.
- V_SYNC, 2, vsync width in lines.
- V_BACK, 33, vertical back porch.
- SYNC_ACTIVE_LOW, 1, 1 means syncs are asserted low, 0 means asserted high.

Derived (localparams):
- H_WHOLE = H_VISIBLE+H_FRONT+H_SYNC+H_BACK
- V_WHOLE = V_VISIBLE+V_FRONT+V_SYNC+V_BACK
- H_SYNC_START = H_VISIBLE+H_FRONT
- V_SYNC_START = V_VISIBLE+V_FRONT
- H_BITS = $clog2(H_WHOLE)
- V_BITS = $clog2(V_WHOLE)

Ports:
- clk  input  1  pixel clock.
- reset_n  input  1  synchronous reset, active low.
- vga_red/vga_grn/vga_blu  input  COLOR_BITS each  incoming colour.
- vga_hsync  input  1  incoming hsync.
- vga_vsync  input  1  incoming vsync.
- pixel_valid  output  1  high for one cycle per decoded visible pixel.
- pixel_x  output  H_BITS  x coordinate.
- pixel_y  output  V_BITS  y coordinate.
- pixel_red/pixel_grn/pixel_blu  output  COLOR_BITS each  decoded colour.
- line_start  output  1  pulse with the pixel where x==0.
- frame_start  output  1  pulse with pixel (0,0).
- locked  output  1  high in state LOCKED.
- h_err  output  1  one-cycle pulse on an hsync timing mismatch.
- v_err  output  1  one-cycle pulse on a vsync timing mismatch.
- frame_count  output  16  frames completed while LOCKED; wraps.
- err_count  output  8  total h_err+v_err events; saturates at 255.

Behaviour:
- Reset: clk is the only clock; reset_n is synchronous, active low. While reset_n==0, on every clk edge:
  - all outputs, counters and sample registers are cleared to 0;
  - state goes to SEARCH.
  - Reset mid-frame takes effect at the next edge; no partial outputs follow.
- Input stage: all inputs registered once (s_*); previous sync values held in p_*.
- Sync polarity: active = (s_sync ^ SYNC_ACTIVE_LOW). An assertion edge is active now and inactive in p_*.
- h counter: free-running h_next = (h==H_WHOLE-1) ? 0 : h+1.
- v counter: advances only when h wraps; wraps from V_WHOLE-1 to 0.
- hsync assertion edge: h loads H_SYNC_START for that sample.
- vsync assertion edge: v loads V_SYNC_START. The h counter is unaffected.
- States:
  - SEARCH: no checks. On an hsync edge -> H_LOCK.
  - H_LOCK: h is checked. On a vsync edge -> LOCKED; no v check on that edge.
  - LOCKED: h and v are checked.
- h check (H_LOCK, LOCKED): on an hsync edge with h_next != H_SYNC_START:
  - h_err pulse;
  - h is realigned;
  - state -> H_LOCK.
- v check (LOCKED only): on a vsync edge with the predicted v != V_SYNC_START:
  - v_err pulse;
  - v is realigned;
  - state -> H_LOCK.
  - "Predicted v" includes any increment from an h wrap on the same cycle.
- Simultaneous h and v errors in one cycle: both pulses fire; err_count increments by 2, saturating.
- Output stage:
  - One registered stage; total latency is 2 clk from input pins to pixel_valid and its data.
  - pixel_valid = LOCKED && h<H_VISIBLE && v<V_VISIBLE, evaluated for the sample after any error handling that cycle. An erroring sample is never valid.
  - pixel_x/pixel_y/pixel_* hold their last values when pixel_valid is low.
- frame_count increments on the cycle frame_start is output.
- locked is registered and aligned with the output stage.

Test Plan:
Bench generator uses H 8/2/3/2 (H_WHOLE 15), V 4/1/2/1 (V_WHOLE 8), active-low syncs, colour = {x, y, x^y}.

1. Reset: reset_n=0 for 5 cycles with random toggling inputs -> every output 0, locked 0; after release and before any hsync edge, no pixel_valid.
2. Clean raster, 3 frames: locked rises after the first vsync edge. Each subsequent frame gives exactly 32 pixel_valid pulses:
   - x 0..7 and y 0..3, in raster order;
   - colours equal to the pattern;
   - data appears 2 clk after the pins;
   - one frame_start, four line_start per frame;
   - frame_count advances 1 per frame.
3. One hsync asserted a pixel early -> single-cycle h_err, err_count=1, locked drops, no valid pixels until the next vsync edge, then clean decoding resumes.
4. One frame with an extra back-porch line (V_WHOLE 9) -> v_err at that vsync edge, err_count=1, relock on the following vsync with correct coordinates.
5. SYNC_ACTIVE_LOW=0 with inverted generator syncs -> same results as scenario 2.
6. reset_n pulsed low mid-line in LOCKED -> outputs 0 on the next edge; relock after the next hsync and vsync edges; frame_count restarts from 0.

Source files
------------

// File: rtl/vga_rx_decoder.sv
// VGA receiver: samples sync and colour on the pixel clock, recovers raster
// position from sync edges and emits decoded pixels plus timing-error pulses.
module vga_rx_decoder #(
  parameter int COLOR_BITS      = 4,
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int SYNC_ACTIVE_LOW = 1,
  localparam int H_WHOLE =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_WHOLE =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT,
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT,
  localparam int H_BITS = $clog2(H_WHOLE),
  localparam int V_BITS = $clog2(V_WHOLE)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [COLOR_BITS-1:0] vga_red,
  input  logic [COLOR_BITS-1:0] vga_grn,
  input  logic [COLOR_BITS-1:0] vga_blu,
  input  logic                  vga_hsync,
  input  logic                  vga_vsync,
  output logic                  pixel_valid,
  output logic [H_BITS-1:0]     pixel_x,
  output logic [V_BITS-1:0]     pixel_y,
  output logic [COLOR_BITS-1:0] pixel_red,
  output logic [COLOR_BITS-1:0] pixel_grn,
  output logic [COLOR_BITS-1:0] pixel_blu,
  output logic                  line_start,
  output logic                  frame_start,
  output logic                  locked,
  output logic                  h_err,
  output logic                  v_err,
  output logic [15:0]           frame_count,
  output logic [7:0]            err_count
);

  localparam logic POL = (SYNC_ACTIVE_LOW != 0);

  localparam logic [H_BITS-1:0] H_LAST =
    H_BITS'(H_WHOLE - 1);
  localparam logic [H_BITS-1:0] H_SS =
    H_BITS'(H_SYNC_START);
  localparam logic [H_BITS-1:0] H_VIS =
    H_BITS'(H_VISIBLE);
  localparam logic [H_BITS-1:0] H_ONE =
    H_BITS'(1);

  localparam logic [V_BITS-1:0] V_LAST =
    V_BITS'(V_WHOLE - 1);
  localparam logic [V_BITS-1:0] V_SS =
    V_BITS'(V_SYNC_START);
  localparam logic [V_BITS-1:0] V_VIS =
    V_BITS'(V_VISIBLE);
  localparam logic [V_BITS-1:0] V_ONE =
    V_BITS'(1);

  typedef enum logic [1:0] {
    SEARCH,
    H_LOCK,
    LOCKED
  } state_t;

  state_t state;
  state_t state_n;

  logic [COLOR_BITS-1:0] s_red;
  logic [COLOR_BITS-1:0] s_grn;
  logic [COLOR_BITS-1:0] s_blu;
  logic                  s_hsync;
  logic                  s_vsync;
  logic                  p_hsync;
  logic                  p_vsync;

  logic [H_BITS-1:0] h;
  logic [H_BITS-1:0] h_next;
  logic [H_BITS-1:0] h_cur;
  logic [V_BITS-1:0] v;
  logic [V_BITS-1:0] v_pred;
  logic [V_BITS-1:0] v_cur;

  logic       h_act;
  logic       v_act;
  logic       h_pact;
  logic       v_pact;
  logic       h_edge;
  logic       v_edge;
  logic       h_wrap;
  logic       h_bad;
  logic       v_bad;
  logic       vis;
  logic       at_x0;
  logic       at_y0;
  logic [1:0] err_inc;
  logic [8:0] err_sum;

  assign h_act  = s_hsync ^ POL;
  assign v_act  = s_vsync ^ POL;
  assign h_pact = p_hsync ^ POL;
  assign v_pact = p_vsync ^ POL;
  assign h_edge = h_act && !h_pact;
  assign v_edge = v_act && !v_pact;

  // h/v hold the position of the previous sample;
  // *_next and *_pred are where this sample should land.
  assign h_wrap = (h == H_LAST);
  assign h_next = h_wrap ? '0 : h + H_ONE;

  always_comb begin
    v_pred = v;
    if (h_wrap) begin
      v_pred = (v == V_LAST) ? '0 : v + V_ONE;
    end
  end

  assign h_bad = h_edge
              && (state != SEARCH)
              && (h_next != H_SS);
  assign v_bad = v_edge
              && (state == LOCKED)
              && (v_pred != V_SS);

  assign h_cur = h_edge ? H_SS : h_next;
  assign v_cur = v_edge ? V_SS : v_pred;

  always_comb begin
    state_n = state;
    unique case (1'b1)
      h_bad || v_bad:
        state_n = H_LOCK;
      (state == SEARCH) && h_edge:
        state_n = H_LOCK;
      (state == H_LOCK) && v_edge && !h_bad:
        state_n = LOCKED;
      default: ;
    endcase
  end

  // An erroring sample always leaves state_n at H_LOCK,
  // so it can never be flagged as a visible pixel.
  assign vis = (state_n == LOCKED)
            && (h_cur < H_VIS)
            && (v_cur < V_VIS);

  assign at_x0 = (h_cur == '0);
  assign at_y0 = (v_cur == '0);

  assign err_inc = {1'b0, h_bad} + {1'b0, v_bad};
  assign err_sum = {1'b0, err_count} + {7'b0, err_inc};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_red       <= '0;
      s_grn       <= '0;
      s_blu       <= '0;
      s_hsync     <= 1'b0;
      s_vsync     <= 1'b0;
      p_hsync     <= 1'b0;
      p_vsync     <= 1'b0;
      h           <= '0;
      v           <= '0;
      state       <= SEARCH;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_red   <= '0;
      pixel_grn   <= '0;
      pixel_blu   <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      s_red   <= vga_red;
      s_grn   <= vga_grn;
      s_blu   <= vga_blu;
      s_hsync <= vga_hsync;
      s_vsync <= vga_vsync;
      p_hsync <= s_hsync;
      p_vsync <= s_vsync;

      h     <= h_cur;
      v     <= v_cur;
      state <= state_n;

      locked      <= (state_n == LOCKED);
      pixel_valid <= vis;
      line_start  <= vis && at_x0;
      frame_start <= vis && at_x0 && at_y0;
      h_err       <= h_bad;
      v_err       <= v_bad;

      if (vis) begin
        pixel_x   <= h_cur;
        pixel_y   <= v_cur;
        pixel_red <= s_red;
        pixel_grn <= s_grn;
        pixel_blu <= s_blu;
      end

      if (vis && at_x0 && at_y0) begin
        frame_count <= frame_count + 16'd1;
      end

      if (h_bad || v_bad) begin
        err_count <= err_sum[8] ? 8'hFF
                                : err_sum[7:0];
      end
    end
  end

endmodule
